// File: rtl/wb_pkg.sv
// Shared types and helpers for the ofmap writeback block.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } wb_state_t;

    localparam int unsigned WB_DATA_W = 32;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Flop-based synchronous FIFO with occupancy counter and synchronous clear.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        full,
    output logic                        empty,
    output logic [level_w(DEPTH)-1:0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;

endmodule

// File: rtl/ofmap_writeback.sv
// Buffers the post-PPU ofmap stream and writes it to DRAM at incrementing
// byte addresses, flagging any word lost to back-pressure.
module ofmap_writeback
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W    = WB_DATA_W,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic                        acc_valid,
    input  logic [DATA_W-1:0]           acc_data,
    input  logic                        acc_done,
    output logic                        dram_req,
    output logic [ADDR_W-1:0]           dram_addr,
    output logic [DATA_W-1:0]           dram_wdata,
    input  logic                        dram_gnt,
    output logic [level_w(DEPTH)-1:0]   fifo_level,
    output logic [15:0]                 word_count,
    output logic                        overflow,
    output logic                        wb_done
);

    localparam int unsigned LW = level_w(DEPTH);

    wb_state_t state;
    wb_state_t state_nxt;

    logic start_job;
    logic push_try;
    logic push;
    logic pop;
    logic drop;
    logic fifo_full;
    logic fifo_empty;
    logic drained;

    assign start_job = start && (state == IDLE);
    assign pop       = dram_req && dram_gnt;
    assign push_try  = acc_valid && (state == RUN);
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push      = push_try && (!fifo_full || pop);
    assign drop      = (push_try && fifo_full && !pop)
                    || (acc_valid && ((state == DRAIN) || (state == FINISH)));
    assign drained   = fifo_empty || ((fifo_level == LW'(1)) && pop);

    wb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_job),
        .push  (push),
        .pop   (pop),
        .wdata (acc_data),
        .rdata (dram_wdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (acc_done) state_nxt = DRAIN;
            DRAIN:   if (drained)  state_nxt = FINISH;
            FINISH:                state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dram_req = 1'b0;
        wb_done  = 1'b0;
        case (state)
            RUN, DRAIN: dram_req = !fifo_empty;
            FINISH:     wb_done  = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dram_addr  <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (start_job) begin
            dram_addr  <= base_addr;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pop) begin
                dram_addr  <= dram_addr + ADDR_W'(ADDR_STEP);
                word_count <= word_count + 16'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofmap_writeback.sv
// Directed self-checking bench for ofmap_writeback.
module tb_ofmap_writeback;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              acc_valid = 1'b0;
    logic [DATA_W-1:0] acc_data = '0;
    logic              acc_done = 1'b0;
    logic              dram_req;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic              dram_gnt = 1'b0;
    logic [4:0]        fifo_level;
    logic [15:0]       word_count;
    logic              overflow;
    logic              wb_done;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [ADDR_W-1:0] q_addr [$];
    logic [DATA_W-1:0] q_data [$];
    int unsigned       done_cnt   = 0;
    int unsigned       done_beats = 0;

    ofmap_writeback #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .ADDR_STEP (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .acc_valid  (acc_valid),
        .acc_data   (acc_data),
        .acc_done   (acc_done),
        .dram_req   (dram_req),
        .dram_addr  (dram_addr),
        .dram_wdata (dram_wdata),
        .dram_gnt   (dram_gnt),
        .fifo_level (fifo_level),
        .word_count (word_count),
        .overflow   (overflow),
        .wb_done    (wb_done)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so the negedge view equals
    // what the next posedge will see.
    always @(negedge clk) begin
        if (!rst && dram_req && dram_gnt) begin
            q_addr.push_back(dram_addr);
            q_data.push_back(dram_wdata);
        end
        if (!rst && wb_done) begin
            done_cnt++;
            done_beats = q_addr.size();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        start     = 1'b1;
        base_addr = b;
        cyc();
        start     = 1'b0;
    endtask

    task automatic finish_job(input int unsigned d0);
        acc_valid = 1'b0;
        acc_done  = 1'b1;
        cyc();
        acc_done  = 1'b0;
        for (int i = 0; i < 100 && done_cnt == d0; i++) cyc();
        n_checks++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL wb_done_timeout: done_cnt=%0d required >%0d", done_cnt, d0);
        end
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({dram_req, dram_addr, dram_wdata, fifo_level, word_count, overflow, wb_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b addr=%h wdata=%h lvl=%0d wc=%0d ovf=%b done=%b required all zero",
                     dram_req, dram_addr, dram_wdata, fifo_level, word_count, overflow, wb_done);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        int unsigned b  = q_addr.size();
        int unsigned d0 = done_cnt;
        dram_gnt = 1'b1;
        do_start(32'h1000);
        for (int i = 0; i < 8; i++) begin
            acc_valid = 1'b1;
            acc_data  = 32'hA0 + i;
            cyc();
        end
        finish_job(d0);
        n_checks++;
        if (q_addr.size() - b !== 8) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d required 8", q_addr.size() - b);
        end
        for (int i = 0; i < 8; i++) begin
            if (q_addr.size() > b + i) begin
                n_checks++;
                if (q_addr[b+i] !== 32'h1000 + 4*i || q_data[b+i] !== 32'hA0 + i) begin
                    n_fail++;
                    $display("FAIL basic_beat%0d: addr=%h data=%h required addr=%h data=%h",
                             i, q_addr[b+i], q_data[b+i], 32'h1000 + 4*i, 32'hA0 + i);
                end
            end
        end
        n_checks++;
        if (word_count !== 16'd8) begin
            n_fail++;
            $display("FAIL basic_word_count: got %0d required 8", word_count);
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL basic_done_pulses: got %0d required 1", done_cnt - d0);
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_overflow: got %b required 0", overflow);
        end
    endtask

    task automatic test_back_pressure();
        int unsigned b  = q_addr.size();
        int unsigned d0 = done_cnt;
        dram_gnt = 1'b0;
        do_start(32'h2000);
        for (int i = 0; i < 16; i++) begin
            acc_valid = 1'b1;
            acc_data  = 32'hB0 + i;
            cyc();
        end
        acc_valid = 1'b0;
        n_checks++;
        if (fifo_level !== 5'd16 || dram_req !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full: lvl=%0d req=%b required lvl=16 req=1", fifo_level, dram_req);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dram_wdata !== 32'hB0 || dram_addr !== 32'h2000) begin
                n_fail++;
                $display("FAIL bp_stable%0d: wdata=%h addr=%h required wdata=000000b0 addr=00002000",
                         k, dram_wdata, dram_addr);
            end
            cyc();
        end
        dram_gnt = 1'b1;
        finish_job(d0);
        n_checks++;
        if (q_addr.size() - b !== 16) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d required 16", q_addr.size() - b);
        end
        for (int i = 0; i < 16; i++) begin
            if (q_addr.size() > b + i) begin
                n_checks++;
                if (q_addr[b+i] !== 32'h2000 + 4*i || q_data[b+i] !== 32'hB0 + i) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: addr=%h data=%h required addr=%h data=%h",
                             i, q_addr[b+i], q_data[b+i], 32'h2000 + 4*i, 32'hB0 + i);
                end
            end
        end
        n_checks++;
        if (word_count !== 16'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_final: wc=%0d ovf=%b required wc=16 ovf=0", word_count, overflow);
        end
    endtask

    task automatic test_overflow();
        int unsigned b  = q_addr.size();
        int unsigned d0 = done_cnt;
        dram_gnt = 1'b0;
        do_start(32'h3000);
        for (int i = 0; i < 17; i++) begin
            acc_valid = 1'b1;
            acc_data  = (i == 16) ? 32'hDEAD : 32'hC0 + i;
            cyc();
        end
        acc_valid = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || fifo_level !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b lvl=%0d required ovf=1 lvl=16", overflow, fifo_level);
        end
        dram_gnt = 1'b1;
        finish_job(d0);
        n_checks++;
        if (q_addr.size() - b !== 16 || q_data[q_data.size()-1] !== 32'hCF) begin
            n_fail++;
            $display("FAIL ovf_beats: count=%0d last=%h required count=16 last=000000cf",
                     q_addr.size() - b, q_data[q_data.size()-1]);
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b required 1", overflow);
        end

        b  = q_addr.size();
        d0 = done_cnt;
        dram_gnt = 1'b0;
        do_start(32'h4000);
        for (int i = 0; i < 16; i++) begin
            acc_valid = 1'b1;
            acc_data  = 32'hD0 + i;
            cyc();
        end
        dram_gnt = 1'b1;
        acc_data = 32'hE0;
        cyc();
        acc_valid = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || fifo_level !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_pop_push: ovf=%b lvl=%0d required ovf=0 lvl=16", overflow, fifo_level);
        end
        finish_job(d0);
        n_checks++;
        if (q_addr.size() - b !== 17 || q_data[q_data.size()-1] !== 32'hE0
            || q_addr[q_addr.size()-1] !== 32'h4040) begin
            n_fail++;
            $display("FAIL ovf_accept: count=%0d last=%h@%h required count=17 last=000000e0@00004040",
                     q_addr.size() - b, q_data[q_data.size()-1], q_addr[q_addr.size()-1]);
        end
        n_checks++;
        if (overflow !== 1'b0 || word_count !== 16'd17) begin
            n_fail++;
            $display("FAIL ovf_accept_final: ovf=%b wc=%0d required ovf=0 wc=17", overflow, word_count);
        end
    endtask

    task automatic test_done_edges();
        int unsigned b  = q_addr.size();
        int unsigned d0 = done_cnt;
        dram_gnt = 1'b1;
        do_start(32'h5000);
        for (int i = 0; i < 3; i++) begin
            acc_valid = 1'b1;
            acc_data  = 32'hF0 + i;
            acc_done  = (i == 2);
            cyc();
        end
        acc_valid = 1'b0;
        acc_done  = 1'b0;
        for (int i = 0; i < 50 && done_cnt == d0; i++) cyc();
        cyc();
        n_checks++;
        if (done_beats - b !== 3 || q_data[q_data.size()-1] !== 32'hF2 || word_count !== 16'd3) begin
            n_fail++;
            $display("FAIL done_with_last: beats_at_done=%0d last=%h wc=%0d required 3 000000f2 3",
                     done_beats - b, q_data[q_data.size()-1], word_count);
        end

        b  = q_addr.size();
        d0 = done_cnt;
        do_start(32'h6000);
        cyc();
        acc_done = 1'b1;
        cyc();
        acc_done = 1'b0;
        n_checks++;
        if (wb_done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_empty_early: wb_done=%b required 0", wb_done);
        end
        cyc();
        n_checks++;
        if (wb_done !== 1'b1 || word_count !== 16'd0) begin
            n_fail++;
            $display("FAIL done_empty_pulse: wb_done=%b wc=%0d required 1 0", wb_done, word_count);
        end
        cyc();
        n_checks++;
        if (wb_done !== 1'b0 || done_cnt - d0 !== 1 || q_addr.size() != b) begin
            n_fail++;
            $display("FAIL done_empty_after: wb_done=%b pulses=%0d beats=%0d required 0 1 0",
                     wb_done, done_cnt - d0, q_addr.size() - b);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned b;
        int unsigned d0;
        dram_gnt = 1'b0;
        do_start(32'h7000);
        for (int i = 0; i < 5; i++) begin
            acc_valid = 1'b1;
            acc_data  = 32'h70 + i;
            cyc();
        end
        acc_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dram_req !== 1'b0 || fifo_level !== 5'd0 || word_count !== 16'd0 || dram_addr !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: req=%b lvl=%0d wc=%0d addr=%h required 0 0 0 0",
                     dram_req, fifo_level, word_count, dram_addr);
        end
        cyc();
        rst = 1'b0;
        dram_gnt = 1'b1;
        acc_valid = 1'b1;
        acc_data  = 32'h99;
        cyc();
        acc_valid = 1'b0;
        cyc();
        n_checks++;
        if (fifo_level !== 5'd0 || overflow !== 1'b0 || dram_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: lvl=%0d ovf=%b req=%b required 0 0 0", fifo_level, overflow, dram_req);
        end
        b  = q_addr.size();
        d0 = done_cnt;
        do_start(32'h8000);
        acc_valid = 1'b1;
        acc_data  = 32'h11;
        cyc();
        acc_data  = 32'h22;
        cyc();
        finish_job(d0);
        n_checks++;
        if (q_addr.size() - b !== 2 || q_addr[b] !== 32'h8000 || q_data[b] !== 32'h11
            || q_addr[b+1] !== 32'h8004 || q_data[b+1] !== 32'h22) begin
            n_fail++;
            $display("FAIL rst_restart: count=%0d first=%h@%h required 2 00000011@00008000",
                     q_addr.size() - b, q_data[b], q_addr[b]);
        end
    endtask

    task automatic test_wrap();
        int unsigned b  = q_addr.size();
        int unsigned d0 = done_cnt;
        logic [ADDR_W-1:0] exp_a [3];
        exp_a[0] = 32'hFFFF_FFF8;
        exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000;
        dram_gnt = 1'b1;
        do_start(32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) begin
            acc_valid = 1'b1;
            acc_data  = 32'h50 + i;
            cyc();
        end
        finish_job(d0);
        n_checks++;
        if (q_addr.size() - b !== 3) begin
            n_fail++;
            $display("FAIL wrap_beats: got %0d required 3", q_addr.size() - b);
        end
        for (int i = 0; i < 3; i++) begin
            if (q_addr.size() > b + i) begin
                n_checks++;
                if (q_addr[b+i] !== exp_a[i] || q_data[b+i] !== 32'h50 + i) begin
                    n_fail++;
                    $display("FAIL wrap_beat%0d: addr=%h data=%h required addr=%h data=%h",
                             i, q_addr[b+i], q_data[b+i], exp_a[i], 32'h50 + i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_overflow();
        test_done_edges();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
